// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath sizes and result-source indices
// used to steer the result selector.
package alu_pkg;

  localparam int unsigned ALU_W    = 32;
  localparam int unsigned ALU_NSRC = 8;

  localparam int unsigned SRC_ADD = 0;
  localparam int unsigned SRC_SUB = 1;
  localparam int unsigned SRC_AND = 2;
  localparam int unsigned SRC_OR  = 3;
  localparam int unsigned SRC_XOR = 4;
  localparam int unsigned SRC_SHL = 5;
  localparam int unsigned SRC_SHR = 6;
  localparam int unsigned SRC_SLT = 7;

endpackage

// File: rtl/mux_nbit.sv
// Combinational N-input selector; out-of-range selects yield zero data and
// raise sel_err.
module mux_nbit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W,
  parameter int unsigned N_IN  = ALU_NSRC,
  localparam int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      data,
  output logic                  zero,
  output logic                  sel_err
);

  logic [31:0] sel_ext;

  assign sel_ext = {{(32-SEL_W){1'b0}}, sel};

  always_comb begin
    data    = '0;
    sel_err = (sel_ext >= N_IN);
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (sel_ext == k) begin
        data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign zero = ~|data;

endmodule

// File: rtl/result_mux_pipe.sv
// Registered N-input result selector with a valid/ready handshake and a
// two-entry skid buffer so that in_ready comes straight from a flop.
module result_mux_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W,
  parameter int unsigned N_IN  = ALU_NSRC,
  localparam int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_zero,
  output logic                  out_sel_err
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_zero;
  logic             sel_err;

  mux_nbit #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_mux (
    .in_data (in_data),
    .sel     (in_sel),
    .data    (sel_data),
    .zero    (sel_zero),
    .sel_err (sel_err)
  );

  logic [1:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] r0_data_q, r0_data_d;
  logic             r0_zero_q, r0_zero_d;
  logic             r0_err_q, r0_err_d;
  logic [WIDTH-1:0] r1_data_q, r1_data_d;
  logic             r1_zero_q, r1_zero_d;
  logic             r1_err_q, r1_err_d;
  logic             accept;
  logic             drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = (count_q != 2'd0) & out_ready;

  always_comb begin
    count_d   = count_q;
    r0_data_d = r0_data_q;
    r0_zero_d = r0_zero_q;
    r0_err_d  = r0_err_q;
    r1_data_d = r1_data_q;
    r1_zero_d = r1_zero_q;
    r1_err_d  = r1_err_q;
    case (count_q)
      2'd0: begin
        if (accept) begin
          r0_data_d = sel_data;
          r0_zero_d = sel_zero;
          r0_err_d  = sel_err;
          count_d   = 2'd1;
        end
      end
      2'd1: begin
        if (accept && drain) begin
          r0_data_d = sel_data;
          r0_zero_d = sel_zero;
          r0_err_d  = sel_err;
        end else if (accept) begin
          r1_data_d = sel_data;
          r1_zero_d = sel_zero;
          r1_err_d  = sel_err;
          count_d   = 2'd2;
        end else if (drain) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        // in_ready is low here, so only a drain can happen
        if (drain) begin
          r0_data_d = r1_data_q;
          r0_zero_d = r1_zero_q;
          r0_err_d  = r1_err_q;
          count_d   = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      r0_data_q  <= '0;
      r0_zero_q  <= 1'b0;
      r0_err_q   <= 1'b0;
      r1_data_q  <= '0;
      r1_zero_q  <= 1'b0;
      r1_err_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      r0_data_q  <= r0_data_d;
      r0_zero_q  <= r0_zero_d;
      r0_err_q   <= r0_err_d;
      r1_data_q  <= r1_data_d;
      r1_zero_q  <= r1_zero_d;
      r1_err_q   <= r1_err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_data    = r0_data_q;
  assign out_zero    = r0_zero_q;
  assign out_sel_err = r0_err_q;

endmodule

// File: tb/tb_result_mux_pipe.sv
// Directed and randomised checks of result_mux_pipe in three configurations:
// default 32x8, 16x5 (random traffic) and 32x6 (out-of-range selects).
module tb_result_mux_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero, a_out_err;
  logic [255:0] a_in_data;
  logic [2:0]   a_in_sel;
  logic [31:0]  a_out_data;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero, b_out_err;
  logic [79:0]  b_in_data;
  logic [2:0]   b_in_sel;
  logic [15:0]  b_out_data;

  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_zero, c_out_err;
  logic [191:0] c_in_data;
  logic [2:0]   c_in_sel;
  logic [31:0]  c_out_data;

  result_mux_pipe u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (a_in_valid),
    .in_ready    (a_in_ready),
    .in_data     (a_in_data),
    .in_sel      (a_in_sel),
    .out_valid   (a_out_valid),
    .out_ready   (a_out_ready),
    .out_data    (a_out_data),
    .out_zero    (a_out_zero),
    .out_sel_err (a_out_err)
  );

  result_mux_pipe #(.WIDTH(16), .N_IN(5)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .in_data     (b_in_data),
    .in_sel      (b_in_sel),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
    .out_data    (b_out_data),
    .out_zero    (b_out_zero),
    .out_sel_err (b_out_err)
  );

  result_mux_pipe #(.WIDTH(32), .N_IN(6)) u_dut_c (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (c_in_valid),
    .in_ready    (c_in_ready),
    .in_data     (c_in_data),
    .in_sel      (c_in_sel),
    .out_valid   (c_out_valid),
    .out_ready   (c_out_ready),
    .out_data    (c_out_data),
    .out_zero    (c_out_zero),
    .out_sel_err (c_out_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic c_op(input logic [2:0] sel, input logic [31:0] ed, input logic ez,
                      input logic ee);
    c_in_sel   = sel;
    c_in_valid = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0;
    check("c_valid", 32'(c_out_valid), 32'd1);
    check("c_data", c_out_data, ed);
    check("c_zero", 32'(c_out_zero), 32'(ez));
    check("c_sel_err", 32'(c_out_err), 32'(ee));
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [15:0] d;
    logic        z;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  exp_t        ex;
  exp_t        prev;
  logic        stall_prev;
  logic [15:0] slot;
  int          sent;
  int          rcvd;
  int          cyc;

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0; a_in_sel = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0; b_in_sel = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = '0; c_in_sel = '0;

    // Reset for two edges
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_out_data", a_out_data, 32'd0);
    check("rst_out_zero", 32'(a_out_zero), 32'd0);
    check("rst_out_sel_err", 32'(a_out_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(a_in_ready), 32'd1);

    // Single op
    a_out_ready = 1'b1;
    a_in_data[3*32 +: 32] = 32'hDEADBEEF;
    a_in_sel   = 3'd3;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    check("single_valid", 32'(a_out_valid), 32'd1);
    check("single_data", a_out_data, 32'hDEADBEEF);
    check("single_zero", 32'(a_out_zero), 32'd0);
    check("single_sel_err", 32'(a_out_err), 32'd0);
    @(negedge clk);
    check("single_drained", 32'(a_out_valid), 32'd0);

    // Backpressure: fill both entries, then drain in order
    a_out_ready = 1'b0;
    a_in_data[1*32 +: 32] = 32'h11;
    a_in_data[2*32 +: 32] = 32'h22;
    a_in_sel   = 3'd1;
    a_in_valid = 1'b1;
    @(negedge clk);
    check("bp_ready_after_1", 32'(a_in_ready), 32'd1);
    a_in_sel = 3'd2;
    @(negedge clk);
    a_in_valid = 1'b0;
    check("bp_ready_full", 32'(a_in_ready), 32'd0);
    check("bp_head_data", a_out_data, 32'h11);
    @(negedge clk);
    check("bp_stall_data", a_out_data, 32'h11);
    check("bp_stall_valid", 32'(a_out_valid), 32'd1);
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_second_data", a_out_data, 32'h22);
    check("bp_ready_back", 32'(a_in_ready), 32'd1);
    @(negedge clk);
    check("bp_empty", 32'(a_out_valid), 32'd0);

    // Streaming: one op per cycle, in_ready never drops
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 8; k++) a_in_data[k*32 +: 32] = 32'hA000_0000 + 32'(i * 16 + k);
      a_in_sel   = 3'(i % 8);
      a_in_valid = 1'b1;
      @(negedge clk);
      check("stream_in_ready", 32'(a_in_ready), 32'd1);
      check("stream_valid", 32'(a_out_valid), 32'd1);
      check("stream_data", a_out_data, 32'hA000_0000 + 32'(i * 16 + i % 8));
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    check("stream_empty", 32'(a_out_valid), 32'd0);

    // Reset while holding two ops
    a_out_ready = 1'b0;
    a_in_data[4*32 +: 32] = 32'h33;
    a_in_data[5*32 +: 32] = 32'h44;
    a_in_sel   = 3'd4;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_sel = 3'd5;
    @(negedge clk);
    a_in_valid = 1'b0;
    check("mid_full", 32'(a_in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 32'(a_out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(a_in_ready), 32'd0);
    check("mid_rst_data", a_out_data, 32'd0);
    a_out_ready = 1'b1;
    @(negedge clk);
    check("mid_post_in_ready", 32'(a_in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("mid_no_stale", 32'(a_out_valid), 32'd0);
      @(negedge clk);
    end

    // Out-of-range and zero results on the 6-input instance
    c_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) c_in_data[k*32 +: 32] = 32'h1000_0000 + 32'(k);
    c_op(3'd7, 32'd0, 1'b1, 1'b1);
    c_op(3'd6, 32'd0, 1'b1, 1'b1);
    c_op(3'd5, 32'h1000_0005, 1'b0, 1'b0);
    c_in_data[31:0] = 32'd0;
    c_op(3'd0, 32'd0, 1'b1, 1'b0);

    // Random valid/ready traffic on the 16x5 instance
    sent = 0;
    rcvd = 0;
    cyc = 0;
    stall_prev = 1'b0;
    prev = '0;
    while ((sent < 10000 || sb.size() != 0) && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      if (stall_prev) begin
        check("b_stall_stable", 32'({b_out_data, b_out_zero, b_out_err}), 32'(prev));
      end
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_in_valid  = (sent < 10000) && ($urandom_range(0, 2) != 0);
      b_in_sel    = 3'($urandom_range(0, 7));
      for (int k = 0; k < 5; k++) begin
        slot = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        b_in_data[k*16 +: 16] = slot;
      end
      if (b_out_valid && b_out_ready) begin
        if (sb.size() == 0) begin
          check("b_spurious_output", 32'd1, 32'd0);
        end else begin
          ex = sb.pop_front();
          check("b_result", 32'({b_out_data, b_out_zero, b_out_err}), 32'(ex));
          rcvd++;
        end
      end
      if (b_in_valid && b_in_ready) begin
        if (b_in_sel < 3'd5) ex.d = b_in_data[b_in_sel*16 +: 16];
        else ex.d = 16'h0;
        ex.z = (ex.d == 16'h0);
        ex.e = (b_in_sel >= 3'd5);
        sb.push_back(ex);
        sent++;
      end
      stall_prev = b_out_valid && !b_out_ready;
      prev = {b_out_data, b_out_zero, b_out_err};
    end
    b_in_valid = 1'b0;
    @(negedge clk);
    check("b_sent", 32'(sent), 32'd10000);
    check("b_rcvd", 32'(rcvd), 32'd10000);
    check("b_sb_empty", 32'(sb.size()), 32'd0);
    check("b_final_idle", 32'(b_out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_mux_pipe.md
Name: result_mux_pipe

Overview:
- Parametrised, registered N-input result selector for the ALU output path.
- Successor to the fixed 8-input/32-bit combinational result mux.
- Selects one of N_IN operand-unit results by index and registers it behind a valid/ready handshake with a 2-entry skid buffer, so in_ready is register-driven.
- Also flags zero results and out-of-range selects; sits between the ALU functional units and the writeback/flag logic.

Parameters:
- WIDTH, 32, data width of each input and the output.
- N_IN, 8, number of selectable inputs (2..16, need not be a power of two).
- SEL_W, $clog2(N_IN), select width; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has an operation this cycle.
- in_ready  output  1  block accepts the operation this cycle; a registered output.
- in_data  input  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  index of the input to forward.
- out_valid  output  1  out_* holds a valid result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  selected result.
- out_zero  output  1  out_data == 0.
- out_sel_err  output  1  in_sel was >= N_IN; out_data is forced to 0 in that case.

Behaviour:
- Handshakes:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
- Capture and latency:
  - Selection is combinational on in_data/in_sel at the transfer cycle.
  - The result {data, zero, sel_err} is captured into storage.
  - Latency is 1 cycle: an accepted op appears on out_* the next cycle if the output register was empty or drained.
- Storage:
  - Output register (R0) drives out_*.
  - Skid register (R1) holds at most one op.
  - Occupancy count is 0..2.
- in_ready = (count < 2) computed from next-state and registered. in_ready is 1 while count <= 1 after the edge.
- Event table, evaluated each cycle with accept = in transfer and drain = out transfer:
  - count 0, accept: R0 <= new; count 1.
  - count 1, accept & drain: R0 <= new; count 1.
  - count 1, accept only: R1 <= new; count 2; in_ready drops next cycle.
  - count 1, drain only: count 0.
  - count 2, drain: R0 <= R1; count 1; in_ready rises next cycle. Accept is impossible at count 2.
  - No event: hold all state.
- Ordering: strict FIFO; never reorder or drop.
- Output stability: while out_valid && !out_ready, out_data, out_zero and out_sel_err are stable.
- Out-of-range select: in_sel >= N_IN gives data 0, zero 1, sel_err 1. The op is still accepted and forwarded.
- Reset (rst high at an edge):
  - out_valid 0, out_data 0, out_zero 0, out_sel_err 0, count 0, in_ready 0.
  - in_ready becomes 1 on the first edge with rst low.
  - Reset mid-operation discards both stored ops; no partial output.
- Width rules: no arithmetic on data; out_zero is a WIDTH-wide NOR of the selected value.
- The block asserts nothing about upstream holding in_valid; a deasserted in_valid simply means no accept.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_W = 32 and ALU_NSRC = 8 defaults.
  - The result-source index constants (e.g. SRC_ADD, SRC_SUB, SRC_AND, SRC_OR, SRC_XOR, SRC_SHL, SRC_SHR, SRC_SLT).
- One sub-module, mux_nbit (parametrised WIDTH/N_IN combinational selector with sel_err output).
- Storage, count and handshake logic live in result_mux_pipe.

Test Plan:
- Single op: rst 2 cycles, then in_valid=1, in_sel=3, input3=32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=DEADBEEF, out_zero=0, out_sel_err=0.
- Backpressure: out_ready=0, send ops sel=1 (0x11) then sel=2 (0x22) -> count 2, in_ready=0 on following cycle. Raise out_ready -> outputs 0x11 then 0x22 in order, out_data stable while stalled.
- Streaming: out_ready=1, in_valid=1 for 16 cycles, sel cycling 0..7 -> 16 outputs back-to-back, in_ready constantly 1, values matching the inputs.
- Zero/error: N_IN=6, in_sel=7 -> out_data=0, out_zero=1, out_sel_err=1. in_sel=0 with input0=0 -> out_zero=1, out_sel_err=0.
- Reset mid-operation: fill to count 2, assert rst 1 cycle -> out_valid=0, in_ready=0 that cycle, in_ready=1 next, no stale output ever appears.
- Random valid/ready toggling, 10k ops, WIDTH=16, N_IN=5 -> scoreboard matches, no loss or duplication.
